spi_slave_fe: RTL and testbench
===============================

# spi_slave_fe

SPI slave front end for the register controller: synchronises the external SPI pins (`sclk`, `ss`, `mosi`) into the `clk` domain and deserialises each `ss`-framed transfer into a `DATA_W`-bit word. It serialises a parallel word back onto `miso` and emits single-cycle `ss` edge strobes. It sits directly upstream of the SPI protocol stage. Its `data_out`, `ss_pos_edge` and `ss_neg_edge` drive that stage's `data_fe_in`, `ss_pos_edge` and `ss_neg_edge`, and its `data_in` is driven by that stage's `data_fe_out`.

## Interface
- `DATA_W`, from shared defines (32): word width.
- `SYNC_STAGES`, 2: flops per pin synchroniser, minimum 2.
- `clk` in 1: system clock, the only clock.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `sclk` in 1: SPI clock, asynchronous to `clk`, mode 0 (idles low).
- `ss` in 1: slave select, active-low, asynchronous.
- `mosi` in 1: serial data in, asynchronous.
- `miso` out 1: serial data out.
- `miso_oe` out 1: output enable for the `miso` pad driver.
- `data_in` in `DATA_W`: word to transmit, sampled at frame start.
- `data_out` out `DATA_W`: last received word.
- `ss_neg_edge` out 1: 1-cycle strobe at frame start.
- `ss_pos_edge` out 1: 1-cycle strobe at frame end; `data_out` is valid in the same cycle.

## Operation
- Synchronisers:
  - `ss_s` resets to 1.
  - `sclk_s` and `mosi_s` reset to 0.
  - One extra flop per signal holds the previous value for edge detection.
- Edges:
  - `ss` fall: `ss_s`=0 and previous=1.
  - `ss` rise: `ss_s`=1 and previous=0.
  - `sclk` rise and fall detected the same way on `sclk_s`.
- States: IDLE (`ss_s`=1) and ACTIVE (`ss_s`=0).
  - IDLE→ACTIVE on `ss` fall:
    - clear `rx`.
    - clear `bit_cnt`.
    - load `tx` <= `data_in`.
    - `miso` <= `data_in[DATA_W-1]`.
  - ACTIVE, `sclk` rise:
    - `rx` <= {`rx[DATA_W-2:0]`, `mosi_s`}.
    - `bit_cnt` increments, saturating at `DATA_W`.
  - ACTIVE, `sclk` fall: `tx` shifts left with zero fill, and `miso` <= the new MSB.
  - ACTIVE→IDLE on `ss` rise: `data_out` <= `rx`.
- Partial frames (fewer than `DATA_W` bits): the word is right-aligned and zero-extended. This is required because the protocol stage's config word is `ADDR_W`+1 bits.
- Frames longer than `DATA_W` bits: the last `DATA_W` bits are retained.
- After `DATA_W` falling edges, `miso` outputs 0.
- `sclk` and `mosi` activity while IDLE is ignored.
- `miso_oe` = ~`ss_s`.
- `miso` = 0 while IDLE.

## Timing
- Reset values: `data_out`=0, `miso`=0, `miso_oe`=0, `ss_pos_edge`=0, `ss_neg_edge`=0.
  - Internal `tx`, `rx` and `bit_cnt` reset to 0.
  - State resets to IDLE.
- No strobes are produced on reset release, including when `ss` is already low. The frame starts only on a subsequent `ss` fall.
- Strobe latency from an `ss` pin edge: `SYNC_STAGES`+2 `clk` cycles, registered.
  - `ss_pos_edge` and the `data_out` update occur in the same cycle.
  - `data_out` is held until the next frame end.
- `miso` update latency from an `sclk` pin fall: `SYNC_STAGES`+2 cycles.
- Legal `sclk` rate: each `sclk` half-period ≥ (`SYNC_STAGES`+3) `clk` periods, i.e. f_sclk ≤ f_clk/10 at the default.
- `mosi` must be stable ≥ `SYNC_STAGES`+2 `clk` cycles around each `sclk` rise.
- Simultaneous events in one cycle:
  - `ss` rise with an `sclk` edge: the `ss` edge wins and the `sclk` edge is discarded.
  - `ss` fall with an `sclk` edge: the `sclk` edge is discarded.
- Reset mid-frame:
  - All state is cleared immediately.
  - No `ss_pos_edge` is issued for the aborted frame.
  - The next frame starts only on a fresh `ss` fall.

## Structure
- `DATA_W` and `ADDR_W` stay in the shared defines header used by the whole controller. No new constants are added there.
- `bit_cnt` width is $clog2(`DATA_W`+1), local.
- Sub-module `spi_sync`:
  - `SYNC_STAGES`-deep synchroniser with parameter `RST_VAL`.
  - Instantiated three times.
- Edge detection, the shift registers and the state logic remain in `spi_slave_fe`.

## Test plan
- Reset:
  - Hold `rst`=0 with pins toggling → every output stays 0.
  - Release with `ss`=0 → no strobe.
- Write frame: drive `ss` low, then shift 32 bits of 0xA5A51234 MSB-first, then raise `ss` → exactly one `ss_neg_edge`, then one `ss_pos_edge` with `data_out`=0xA5A51234 in that cycle.
- Read frame: `data_in`=0xDEADBEEF before the `ss` fall → `miso` carries 0xDEADBEEF MSB-first, sampled on `sclk` rises, and `miso_oe`=1 only while selected.
- Short/long frames:
  - 9-bit frame 0x1FF → `data_out`=0x000001FF.
  - 40-bit frame → last 32 bits are kept.
  - `miso`=0 after bit 32.
- Boundaries: an `ss` rise coincident with an `sclk` rise → that bit is dropped. With `ss` high, toggling `sclk` and `mosi` for 50 edges → no `data_out` change.
- Reset mid-frame after 10 bits → no `ss_pos_edge`. The next full frame 0x00000042 is received correctly.

Source files
------------

// File: rtl/spi_slave_fe_pkg.sv
// Shared defines for the SPI register controller: word/address widths and
// the front-end state encoding.
package spi_slave_fe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_fe_if.sv
// SPI pin bundle between an external master and the slave front end.
interface spi_slave_fe_if;

    logic sclk;
    logic ss;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk, ss, mosi,
        input  miso, miso_oe
    );

    modport slave (
        input  sclk, ss, mosi,
        output miso, miso_oe
    );

endinterface

// File: rtl/spi_slave_fe_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a selectable
// reset level so slave select can idle deasserted.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_sr <= {STAGES{RST_VAL}};
        end else begin
            sync_sr <= {sync_sr[STAGES-2:0], d};
        end
    end

    assign q = sync_sr[STAGES-1];

endmodule

// File: rtl/spi_slave_fe.sv
// SPI mode-0 slave front end: synchronises the pins, deserialises ss-framed
// transfers into data_out and serialises data_in onto miso.
module spi_slave_fe #(
    parameter int DATA_W      = spi_slave_fe_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_fe_if.slave     spi,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ss_neg_edge,
    output logic              ss_pos_edge
);

    import spi_slave_fe_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(DATA_W)) ? cnt : cnt + 1'b1;
    endfunction

    logic ss_s, sclk_s, mosi_s;
    logic ss_d, sclk_d;
    logic [SYNC_STAGES:0] arm_sr;
    logic ss_fall_p1, ss_rise_p1, sclk_rise_p1, sclk_fall_p1;

    state_t state, state_nxt;
    logic   start, finish, rx_shift, tx_shift;

    logic [DATA_W-1:0] rx, tx;
    logic [CNT_W-1:0]  bit_cnt;
    logic              miso_q;

    // Stage p0: pin synchronisers
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d(spi.ss), .q(ss_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(spi.mosi), .q(mosi_s)
    );

    // Stage p1: registered edge detection. arm_sr masks edges until the
    // synchronisers hold real pin values, so a low ss at reset release is not
    // mistaken for a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_d         <= 1'b1;
            sclk_d       <= 1'b0;
            arm_sr       <= '0;
            ss_fall_p1   <= 1'b0;
            ss_rise_p1   <= 1'b0;
            sclk_rise_p1 <= 1'b0;
            sclk_fall_p1 <= 1'b0;
        end else begin
            ss_d         <= ss_s;
            sclk_d       <= sclk_s;
            arm_sr       <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
            ss_fall_p1   <= arm_sr[SYNC_STAGES] & ~ss_s &  ss_d;
            ss_rise_p1   <= arm_sr[SYNC_STAGES] &  ss_s & ~ss_d;
            sclk_rise_p1 <= arm_sr[SYNC_STAGES] &  sclk_s & ~sclk_d;
            sclk_fall_p1 <= arm_sr[SYNC_STAGES] & ~sclk_s &  sclk_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ss edges take priority; an sclk edge in the same cycle is dropped
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        rx_shift  = 1'b0;
        tx_shift  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall_p1) begin
                    start     = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_p1) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (sclk_rise_p1) begin
                    rx_shift = 1'b1;
                end else if (sclk_fall_p1) begin
                    tx_shift = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p2: shift registers, output word and strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx          <= '0;
            tx          <= '0;
            bit_cnt     <= '0;
            miso_q      <= 1'b0;
            data_out    <= '0;
            ss_neg_edge <= 1'b0;
            ss_pos_edge <= 1'b0;
        end else begin
            ss_neg_edge <= start;
            ss_pos_edge <= finish;
            if (start) begin
                rx      <= '0;
                bit_cnt <= '0;
                tx      <= data_in;
                miso_q  <= data_in[DATA_W-1];
            end
            if (rx_shift) begin
                rx      <= {rx[DATA_W-2:0], mosi_s};
                bit_cnt <= sat_inc(bit_cnt);
            end
            if (tx_shift) begin
                tx     <= {tx[DATA_W-2:0], 1'b0};
                miso_q <= tx[DATA_W-2];
            end
            if (finish) begin
                data_out <= rx;
                miso_q   <= 1'b0;
            end
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = ~ss_s;

endmodule

// File: tb/tb_spi_slave_fe.sv
// Directed bench for spi_slave_fe: drives SPI mode-0 frames on the pins and
// checks received words, miso contents and ss strobes.
module tb_spi_slave_fe;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ss_neg_edge;
    logic        ss_pos_edge;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          neg_cnt  = 0;
    int          pos_cnt  = 0;
    logic [31:0] pos_data = '0;
    logic [63:0] rd;

    always #5 clk = ~clk;

    spi_slave_fe_if spi_bus ();

    spi_slave_fe #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi_bus),
        .data_in    (data_in),
        .data_out   (data_out),
        .ss_neg_edge(ss_neg_edge),
        .ss_pos_edge(ss_pos_edge)
    );

    always @(negedge clk) begin
        if (ss_neg_edge) neg_cnt++;
        if (ss_pos_edge) begin
            pos_cnt++;
            pos_data = data_out;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic xfer(input logic [63:0] w, input int nbits, output logic [63:0] r);
        r = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bus.mosi = w[i];
            wait_clk(HALF);
            r = {r[62:0], spi_bus.miso};
            spi_bus.sclk = 1'b1;
            wait_clk(HALF);
            spi_bus.sclk = 1'b0;
        end
        wait_clk(HALF);
    endtask

    task automatic frame_begin();
        spi_bus.ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        spi_bus.ss = 1'b1;
        wait_clk(HALF + 2);
    endtask

    initial begin
        rst          = 1'b0;
        data_in      = '0;
        spi_bus.ss   = 1'b1;
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = 1'b0;

        // Reset held with pins toggling: all outputs stay low
        for (int i = 0; i < 6; i++) begin
            spi_bus.sclk = ~spi_bus.sclk;
            spi_bus.mosi = ~spi_bus.mosi;
            spi_bus.ss   = ~spi_bus.ss;
            @(negedge clk);
            check("rst_hold_outs",
                  64'({data_out, spi_bus.miso, spi_bus.miso_oe, ss_pos_edge, ss_neg_edge}), 64'd0);
        end

        // Release with ss already low: no strobes
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = 1'b0;
        spi_bus.ss   = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        wait_clk(20);
        check("rel_ss_low_neg", 64'(neg_cnt), 64'd0);
        check("rel_ss_low_pos", 64'(pos_cnt), 64'd0);
        spi_bus.ss = 1'b1;
        wait_clk(10);
        check("rel_ss_rise_pos", 64'(pos_cnt), 64'd0);
        check("rel_data_out", 64'(data_out), 64'd0);

        // Write frame with ss_neg_edge latency of 4 clk edges
        spi_bus.ss = 1'b0;
        repeat (4) @(negedge clk);
        check("neg_lat_early", 64'(ss_neg_edge), 64'd0);
        @(negedge clk);
        check("neg_lat_hit", 64'(ss_neg_edge), 64'd1);
        @(negedge clk);
        check("neg_lat_late", 64'(ss_neg_edge), 64'd0);
        wait_clk(HALF);
        xfer(64'hA5A51234, 32, rd);
        frame_end();
        check("wr_neg_cnt", 64'(neg_cnt), 64'd1);
        check("wr_pos_cnt", 64'(pos_cnt), 64'd1);
        check("wr_pos_data", 64'(pos_data), 64'hA5A51234);
        check("wr_data_out", 64'(data_out), 64'hA5A51234);

        // Read frame
        data_in = 32'hDEADBEEF;
        frame_begin();
        check("rd_oe_active", 64'(spi_bus.miso_oe), 64'd1);
        xfer(64'd0, 32, rd);
        check("rd_miso_word", rd, 64'hDEADBEEF);
        frame_end();
        check("rd_oe_idle", 64'(spi_bus.miso_oe), 64'd0);
        check("rd_miso_idle", 64'(spi_bus.miso), 64'd0);
        check("rd_data_out", 64'(data_out), 64'd0);
        check("rd_pos_cnt", 64'(pos_cnt), 64'd2);

        // 9-bit frame is right-aligned and zero-extended
        data_in = 32'd0;
        frame_begin();
        xfer(64'h1FF, 9, rd);
        frame_end();
        check("short_data_out", 64'(data_out), 64'h1FF);
        check("short_pos_cnt", 64'(pos_cnt), 64'd3);

        // 40-bit frame keeps the last 32 bits; miso is 0 after bit 32
        data_in = 32'h80000001;
        frame_begin();
        xfer(64'h123456789A, 40, rd);
        frame_end();
        check("long_miso", rd, 64'h8000000100);
        check("long_data_out", 64'(data_out), 64'h3456789A);
        check("long_pos_cnt", 64'(pos_cnt), 64'd4);

        // ss rise coincident with an sclk rise drops that bit
        data_in = 32'd0;
        frame_begin();
        xfer(64'hAB, 8, rd);
        spi_bus.mosi = 1'b1;
        wait_clk(HALF);
        spi_bus.sclk = 1'b1;
        spi_bus.ss   = 1'b1;
        wait_clk(HALF);
        spi_bus.sclk = 1'b0;
        wait_clk(HALF + 2);
        check("coinc_data_out", 64'(data_out), 64'hAB);
        check("coinc_pos_cnt", 64'(pos_cnt), 64'd5);

        // sclk/mosi activity while deselected is ignored
        for (int i = 0; i < 25; i++) begin
            spi_bus.mosi = i[0];
            spi_bus.sclk = 1'b1;
            wait_clk(6);
            spi_bus.sclk = 1'b0;
            wait_clk(6);
        end
        check("idle_data_out", 64'(data_out), 64'hAB);
        check("idle_pos_cnt", 64'(pos_cnt), 64'd5);
        check("idle_neg_cnt", 64'(neg_cnt), 64'd5);

        // Reset after 10 bits aborts the frame without ss_pos_edge
        frame_begin();
        xfer(64'h3FF, 10, rd);
        rst = 1'b0;
        wait_clk(3);
        check("midrst_data_out", 64'(data_out), 64'd0);
        rst = 1'b1;
        wait_clk(10);
        spi_bus.ss = 1'b1;
        wait_clk(10);
        check("midrst_pos_cnt", 64'(pos_cnt), 64'd5);
        check("midrst_neg_cnt", 64'(neg_cnt), 64'd6);

        frame_begin();
        xfer(64'h00000042, 32, rd);
        frame_end();
        check("post_rst_data", 64'(data_out), 64'h42);
        check("post_rst_pos", 64'(pos_cnt), 64'd6);
        check("post_rst_neg", 64'(neg_cnt), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
